// File: rtl/uart_reg_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_reg_ctrl_if
// Description : Bundles the UART receive/transmit handshake and the PWM
//               register bus between the command controller and its peers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_reg_ctrl_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       reg_wr;
    logic       reg_rd;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] err_count;
    logic       busy;

    // Controller side
    modport master (
        input  received, rx_byte, recv_error, is_transmitting, reg_rdata,
        output transmit, tx_byte, reg_wr, reg_rd, reg_addr, reg_wdata,
               err_count, busy
    );

    // UART core / register file side
    modport slave (
        output received, rx_byte, recv_error, is_transmitting, reg_rdata,
        input  transmit, tx_byte, reg_wr, reg_rd, reg_addr, reg_wdata,
               err_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_reg_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_reg_ctrl
// Description : Parses 4-byte frames (A5, CMD, DATA, SUM) from the UART,
//               issues single-cycle register writes/reads and returns a
//               1-byte reply (ACK, NAK or read data) through the UART.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_reg_ctrl #(
    parameter int BAUD_RATE     = 9600,
    parameter int SYS_CLK_FREQ  = 12000000,
    parameter int NUM_REGS      = 8,
    parameter int TIMEOUT_BYTES = 4
) (
    input  wire             clk,
    input  wire             rst,
    uart_reg_ctrl_if.master bus
);

    localparam int          c_reload    = TIMEOUT_BYTES * 10 * SYS_CLK_FREQ / BAUD_RATE;
    localparam int          c_tmo_w     = $clog2(c_reload + 1);
    localparam logic [c_tmo_w-1:0] c_reload_v = c_tmo_w'(c_reload);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
    localparam logic [7:0]  c_sync_byte = 8'hA5;
    localparam logic [7:0]  c_sum_key   = 8'h5A;
    localparam logic [7:0]  c_ack       = 8'h06;
    localparam logic [7:0]  c_nak       = 8'h15;
    localparam logic [7:0]  c_num_regs  = 8'(NUM_REGS);

    localparam logic [2:0] S_SYNC   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_SUM    = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_RDWAIT = 3'd5;
    localparam logic [2:0] S_TXREQ  = 3'd6;
    localparam logic [2:0] S_TXBUSY = 3'd7;

    logic [2:0]         r_state;
    logic [7:0]         r_cmd;
    logic [7:0]         r_data;
    logic               r_ok;
    logic [c_tmo_w-1:0] r_tmo;
    logic               r_transmit;
    logic [7:0]         r_tx_byte;
    logic               r_reg_wr;
    logic               r_reg_rd;
    logic [6:0]         r_reg_addr;
    logic [7:0]         r_reg_wdata;
    logic [7:0]         r_err_count;

    logic               w_sum_ok;
    logic               w_addr_ok;
    logic               w_in_frame;
    logic               w_err_inc;

    // Frame validity and error-event decode
    always_comb begin
        w_sum_ok   = (bus.rx_byte == (r_cmd ^ r_data ^ c_sum_key));
        w_addr_ok  = ({1'b0, r_cmd[6:0]} < c_num_regs);
        w_in_frame = (r_state == S_CMD) || (r_state == S_DATA) || (r_state == S_SUM);
        w_err_inc  = 1'b0;
        if (w_in_frame) begin
            // recv_error aborts; a timeout only counts when no byte arrives
            w_err_inc = bus.recv_error || (!bus.received && (r_tmo == '0));
        end else if (r_state == S_EXEC) begin
            w_err_inc = !r_ok;
        end
    end

    // Frame parser, register strobes and reply handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SYNC;
            r_cmd       <= '0;
            r_data      <= '0;
            r_ok        <= 1'b0;
            r_tmo       <= '0;
            r_transmit  <= 1'b0;
            r_tx_byte   <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
        end else begin
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            case (r_state)
                S_SYNC: begin
                    if (bus.received && (bus.rx_byte == c_sync_byte)) begin
                        r_state <= S_CMD;
                        r_tmo   <= c_reload_v;
                    end
                end
                S_CMD, S_DATA, S_SUM: begin
                    if (bus.recv_error) begin
                        r_state <= S_SYNC;
                    end else if (bus.received) begin
                        // A byte arriving on the expiry cycle still wins
                        r_tmo <= c_reload_v;
                        if (r_state == S_CMD) begin
                            r_cmd   <= bus.rx_byte;
                            r_state <= S_DATA;
                        end else if (r_state == S_DATA) begin
                            r_data  <= bus.rx_byte;
                            r_state <= S_SUM;
                        end else begin
                            // Strobes are registered here so they land in S_EXEC
                            r_ok    <= w_sum_ok && w_addr_ok;
                            r_state <= S_EXEC;
                            if (w_sum_ok && w_addr_ok) begin
                                r_reg_addr <= r_cmd[6:0];
                                if (r_cmd[7]) begin
                                    r_reg_rd <= 1'b1;
                                end else begin
                                    r_reg_wr    <= 1'b1;
                                    r_reg_wdata <= r_data;
                                end
                            end
                        end
                    end else if (r_tmo == '0) begin
                        r_state <= S_SYNC;
                    end else begin
                        r_tmo <= r_tmo - c_tmo_one;
                    end
                end
                S_EXEC: begin
                    if (!r_ok) begin
                        r_tx_byte  <= c_nak;
                        r_transmit <= 1'b1;
                        r_state    <= S_TXREQ;
                    end else if (r_cmd[7]) begin
                        r_state <= S_RDWAIT;
                    end else begin
                        r_tx_byte  <= c_ack;
                        r_transmit <= 1'b1;
                        r_state    <= S_TXREQ;
                    end
                end
                S_RDWAIT: begin
                    r_tx_byte  <= bus.reg_rdata;
                    r_transmit <= 1'b1;
                    r_state    <= S_TXREQ;
                end
                S_TXREQ: begin
                    if (bus.is_transmitting) begin
                        r_transmit <= 1'b0;
                        r_state    <= S_TXBUSY;
                    end
                end
                S_TXBUSY: begin
                    if (!bus.is_transmitting) begin
                        r_state <= S_SYNC;
                    end
                end
                default: begin
                    r_state    <= S_SYNC;
                    r_transmit <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of rejected frames
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.transmit  = r_transmit;
    assign bus.tx_byte   = r_tx_byte;
    assign bus.reg_wr    = r_reg_wr;
    assign bus.reg_rd    = r_reg_rd;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.err_count = r_err_count;
    assign bus.busy      = (r_state != S_SYNC);

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : tb_uart_reg_ctrl
// Description : Self-checking bench for uart_reg_ctrl: table of frames with
//               hand-computed results plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_reg_ctrl;

    typedef struct {
        logic [31:0] frame;      // byte0 in [31:24]
        logic [7:0]  rdata;
        bit          exp_wr;
        bit          exp_rd;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_reply;
        bit          exp_err;
    } vec_t;

    logic clk;
    logic rst;
    uart_reg_ctrl_if bus();

    int n_checks;
    int n_errors;
    int wr_cnt;
    int rd_cnt;
    int both_cnt;
    int tx_cnt;
    bit prev_tx;
    logic [6:0] last_addr;
    logic [7:0] last_wdata;
    vec_t vecs[9];

    uart_reg_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe / transmit observer
    always @(negedge clk) begin
        if (bus.reg_wr) begin
            wr_cnt++;
            last_addr  = bus.reg_addr;
            last_wdata = bus.reg_wdata;
        end
        if (bus.reg_rd) begin
            rd_cnt++;
            last_addr = bus.reg_addr;
        end
        if (bus.reg_wr && bus.reg_rd) both_cnt++;
        if (bus.transmit && !prev_tx) tx_cnt++;
        prev_tx = bus.transmit;
    end

    // Watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_byte  = b;
        bus.received = 1'b1;
        @(posedge clk); #1;
        bus.received = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        send_byte(f[31:24]);
        send_byte(f[23:16]);
        send_byte(f[15:8]);
        send_byte(f[7:0]);
    endtask

    // Acts as the UART transmitter: accept a request, then run the busy phase
    task automatic serve_reply(output logic [7:0] b);
        bit seen;
        seen = 1'b0;
        b = 8'h00;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.transmit) seen = 1'b1;
        end
        check("reply_request_seen", 32'(seen), 32'd1);
        if (seen) begin
            b = bus.tx_byte;
            @(posedge clk); #1;
            bus.is_transmitting = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("transmit_dropped", 32'(bus.transmit), 32'd0);
            check("busy_while_tx", 32'(bus.busy), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            bus.is_transmitting = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("busy_after_tx", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int wr0, rd0;
        logic [7:0] e0, rep;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        e0  = bus.err_count;
        bus.reg_rdata = v.rdata;
        send_frame(v.frame);
        serve_reply(rep);
        check($sformatf("v%0d_wr_pulses", idx), 32'(wr_cnt - wr0), 32'(v.exp_wr));
        check($sformatf("v%0d_rd_pulses", idx), 32'(rd_cnt - rd0), 32'(v.exp_rd));
        if (v.exp_wr || v.exp_rd)
            check($sformatf("v%0d_addr", idx), 32'(last_addr), 32'(v.exp_addr));
        if (v.exp_wr)
            check($sformatf("v%0d_wdata", idx), 32'(last_wdata), 32'(v.exp_wdata));
        check($sformatf("v%0d_reply", idx), 32'(rep), 32'(v.exp_reply));
        check($sformatf("v%0d_err_count", idx), 32'(bus.err_count), 32'(e0 + 8'(v.exp_err)));
    endtask

    initial begin
        logic [7:0] e0, rep;
        int t0, wr0;
        bit seen;

        n_checks = 0; n_errors = 0;
        wr_cnt = 0; rd_cnt = 0; both_cnt = 0; tx_cnt = 0; prev_tx = 1'b0;
        last_addr = '0; last_wdata = '0;

        //          frame          rdata  wr rd addr wdata  reply  err
        vecs[0] = '{32'hA5037F26, 8'h00, 1, 0, 7'd3, 8'h7F, 8'h06, 0};
        vecs[1] = '{32'hA58500DF, 8'hC3, 0, 1, 7'd5, 8'h00, 8'hC3, 0};
        vecs[2] = '{32'hA5037F00, 8'h00, 0, 0, 7'd0, 8'h00, 8'h15, 1};
        vecs[3] = '{32'hA5091142, 8'h00, 0, 0, 7'd0, 8'h00, 8'h15, 1};
        vecs[4] = '{32'hA507AAF7, 8'h00, 1, 0, 7'd7, 8'hAA, 8'h06, 0};
        vecs[5] = '{32'hA5080052, 8'h00, 0, 0, 7'd0, 8'h00, 8'h15, 1};
        vecs[6] = '{32'hA58000DA, 8'h5E, 0, 1, 7'd0, 8'h00, 8'h5E, 0};
        vecs[7] = '{32'hA58733EE, 8'h91, 0, 1, 7'd7, 8'h00, 8'h91, 0};
        vecs[8] = '{32'hA5010259, 8'h00, 1, 0, 7'd1, 8'h02, 8'h06, 0};

        rst = 1'b1;
        bus.received = 1'b0; bus.rx_byte = '0; bus.recv_error = 1'b0;
        bus.is_transmitting = 1'b0; bus.reg_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_transmit", 32'(bus.transmit), 32'd0);
        check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
        check("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        check("rst_reg_rd", 32'(bus.reg_rd), 32'd0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write latency: reg_wr in the cycle after SUM, transmit one cycle later
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h7F); send_byte(8'h26);
        @(negedge clk);
        check("lat_reg_wr", 32'(bus.reg_wr), 32'd1);
        check("lat_transmit_low", 32'(bus.transmit), 32'd0);
        @(negedge clk);
        check("lat_reg_wr_done", 32'(bus.reg_wr), 32'd0);
        check("lat_transmit_high", 32'(bus.transmit), 32'd1);
        check("lat_ack", 32'(bus.tx_byte), 32'h06);
        serve_reply(rep);
        check("lat_reply", 32'(rep), 32'h06);

        // Table of frames
        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // Garbage bytes before a frame are dropped silently
        e0 = bus.err_count;
        send_byte(8'h00); send_byte(8'hFF);
        @(negedge clk);
        check("garbage_idle", 32'(bus.busy), 32'd0);
        apply_vec(vecs[8], 8);
        check("garbage_no_err", 32'(bus.err_count), 32'(e0));

        // Inter-byte timeout
        e0 = bus.err_count;
        t0 = tx_cnt;
        send_byte(8'hA5); send_byte(8'h03);
        repeat (49990) @(posedge clk);
        @(negedge clk);
        check("tmo_not_yet_err", 32'(bus.err_count), 32'(e0));
        check("tmo_not_yet_busy", 32'(bus.busy), 32'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("tmo_err", 32'(bus.err_count), 32'(e0 + 8'd1));
        check("tmo_idle", 32'(bus.busy), 32'd0);
        check("tmo_no_tx", 32'(tx_cnt), 32'(t0));
        apply_vec(vecs[0], 100);

        // recv_error during DATA aborts without a reply
        e0 = bus.err_count;
        t0 = tx_cnt;
        send_byte(8'hA5); send_byte(8'h03);
        @(posedge clk); #1;
        bus.recv_error = 1'b1;
        @(posedge clk); #1;
        bus.recv_error = 1'b0;
        @(negedge clk);
        check("rxerr_idle", 32'(bus.busy), 32'd0);
        check("rxerr_err", 32'(bus.err_count), 32'(e0 + 8'd1));
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rxerr_no_tx", 32'(tx_cnt), 32'(t0));

        // Reset while a reply is being requested
        wr0 = wr_cnt;
        send_frame(32'hA5037F26);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.transmit) seen = 1'b1;
        end
        check("rstmid_request_seen", 32'(seen), 32'd1);
        check("rstmid_wr", 32'(wr_cnt - wr0), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_transmit", 32'(bus.transmit), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_err_clear", 32'(bus.err_count), 32'd0);

        // Error counter saturation
        for (int i = 0; i < 254; i++) begin
            send_frame(32'hA5037F00);
            serve_reply(rep);
        end
        check("sat_254", 32'(bus.err_count), 32'd254);
        for (int i = 0; i < 46; i++) begin
            send_frame(32'hA5037F00);
            serve_reply(rep);
        end
        check("sat_255", 32'(bus.err_count), 32'd255);
        check("sat_last_reply", 32'(rep), 32'h15);

        check("wr_rd_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_reg_ctrl.md
Name: uart_reg_ctrl

Overview:
Command controller that sits between the UART core and the PWM register file. It parses 4-byte binary frames from the UART receive side and issues single-cycle register writes or reads. It returns a 1-byte reply through the UART transmit side, using the transmit / is_transmitting handshake. It is the only master of the PWM register bus and of the UART transmitter.

Parameters:
baud_rate, 9600, UART bit rate; used only for the timeout.
sys_clk_freq, 12000000, clock frequency in Hz.
num_regs, 8, number of valid register addresses (1..128).
timeout_bytes, 4, maximum inter-byte gap in byte times; one byte time = 10*sys_clk_freq/baud_rate cycles (12500 at defaults).

Ports:
clk  input  1  master clock
rst  input  1  synchronous reset, active-high
received  input  1  1-cycle pulse; rx_byte is valid
rx_byte  input  8  received byte
recv_error  input  1  1-cycle pulse; UART framing error
is_transmitting  input  1  high while the UART transmitter is busy
transmit  output  1  request to the UART to send tx_byte
tx_byte  output  8  byte to send
reg_wr  output  1  1-cycle register write strobe
reg_rd  output  1  1-cycle register read strobe
reg_addr  output  7  register address
reg_wdata  output  8  write data
reg_rdata  input  8  read data, valid the cycle after reg_rd
err_count  output  8  saturating count of rejected frames
busy  output  1  high whenever state != S_SYNC

Behaviour:
- Reset: all outputs 0, state S_SYNC, timeout counter 0. Reset mid-frame or mid-reply aborts immediately. transmit drops the next cycle; any UART byte already started completes on the line, with no further action from this block.
- Frame format: 0xA5, CMD, DATA, SUM.
  - CMD[7]=1 is a read, 0 is a write; CMD[6:0] is the address.
  - SUM = CMD ^ DATA ^ 0x5A.
  - DATA is ignored for reads but is still covered by SUM.
- States:
  - S_SYNC: on received, go to S_CMD if rx_byte==0xA5, otherwise discard and stay. Not counted as an error.
  - S_CMD, S_DATA, S_SUM: each latches one byte on received and advances.
  - S_EXEC, one cycle:
    - If SUM mismatches, or addr >= num_regs: reply 0x15 (NAK) and increment err_count.
    - Valid write: reg_wr=1 with reg_addr/reg_wdata for exactly this cycle; reply 0x06 (ACK).
    - Valid read: reg_rd=1; go to S_RDWAIT.
  - S_RDWAIT, one cycle: capture reg_rdata as the reply byte.
  - S_TXREQ: drive transmit=1 with tx_byte held stable. When is_transmitting==1, go to S_TXBUSY with transmit=0.
  - S_TXBUSY: wait for is_transmitting==0, then go to S_SYNC. The UART recovery state requires transmit to be low before it returns to idle, so transmit must never be high in this state.
- Write latency: from the received pulse of the SUM byte, reg_wr is asserted 1 cycle later (S_EXEC). transmit rises on the cycle after that.
- Timeout: the counter reloads to timeout_bytes*10*sys_clk_freq/baud_rate on every accepted byte. It counts down only in S_CMD, S_DATA and S_SUM. On reaching 0: go to S_SYNC, increment err_count, send no reply. Counter width is ceil(log2(reload+1)).
- recv_error:
  - In S_CMD, S_DATA or S_SUM: abort to S_SYNC and increment err_count; no reply.
  - In other states: ignored.
- Bytes received in S_EXEC, S_RDWAIT, S_TXREQ or S_TXBUSY are discarded. The host must wait for the reply before sending the next frame.
- Simultaneous received and timeout expiry in the same cycle: the byte wins and the counter reloads.
- err_count saturates at 255 and is cleared only by rst.
- reg_addr and reg_wdata hold their last values between strobes. reg_wr and reg_rd are never asserted together.

Test Plan:
1. Valid write: send A5 03 7F 26 -> one reg_wr pulse with addr=3, wdata=0x7F; then transmit with tx_byte=0x06; transmit drops on the first cycle is_transmitting is high; busy returns to 0 once is_transmitting falls.
2. Valid read: send A5 85 00 DF with reg_rdata=0xC3 -> reg_rd pulse with addr=5; tx_byte=0xC3; no reg_wr.
3. Bad checksum (A5 03 7F 00) and bad address (A5 09 11 42, valid SUM with num_regs=8) -> no reg_wr; each replies 0x15; err_count goes 0 -> 1 -> 2.
4. Garbage then frame: send 00 FF A5 01 02 59 -> leading bytes ignored; write addr=1, data=0x02; ACK; err_count unchanged.
5. Timeout: send A5 03, then idle for 50001 cycles -> return to S_SYNC, err_count+1, no transmit. A following valid frame is accepted normally.
6. Reset and error handling:
   - recv_error pulse in S_DATA -> abort, err_count+1, no reply.
   - rst asserted during S_TXREQ -> transmit=0 and busy=0 on the next cycle.
   - Drive 300 bad frames -> err_count holds at 255.
